// File: rtl/tia_hcounter.sv
// TIA horizontal timing: color-clock /4 phase strobes, 57-count polynomial line
// counter, and HSYNC/HBLANK decode pulses and levels.
module tia_hcounter #(
  parameter int unsigned WRAP_COUNT = 56
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rsync,
  input  logic       hmove_late,
  output logic       hphi1,
  output logic       hphi2,
  output logic [5:0] lfsr,
  output logic       shs,
  output logic       rhs,
  output logic       rcb,
  output logic       rhb,
  output logic       lrhb,
  output logic       shb,
  output logic       hsync,
  output logic       hblank
);

  localparam int unsigned LFSR_W = 6;
  localparam int unsigned PH_W   = 2;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~(s[LFSR_W-1] ^ s[LFSR_W-2])};
  endfunction

  // Code reached after k advances from all-zeros; evaluated at elaboration.
  function automatic logic [LFSR_W-1:0] code_at(input int unsigned k);
    logic [LFSR_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < k; i++) s = lfsr_step(s);
    return s;
  endfunction

  localparam logic [LFSR_W-1:0] WRAP_CODE = code_at(WRAP_COUNT);
  localparam logic [LFSR_W-1:0] SHB_CODE  = code_at(0);
  localparam logic [LFSR_W-1:0] SHS_CODE  = code_at(4);
  localparam logic [LFSR_W-1:0] RHS_CODE  = code_at(8);
  localparam logic [LFSR_W-1:0] RCB_CODE  = code_at(12);
  localparam logic [LFSR_W-1:0] RHB_CODE  = code_at(16);
  localparam logic [LFSR_W-1:0] LRHB_CODE = code_at(18);

  logic [PH_W-1:0]   ph;
  logic [LFSR_W-1:0] lfsr_next;
  logic              decode_now;

  assign hphi1 = (ph == PH_W'(0));
  assign hphi2 = (ph == PH_W'(2));

  // Decodes are latched on the ph==2 edge so they are visible during ph==3.
  assign decode_now = (ph == PH_W'(2));

  always_comb begin
    lfsr_next = lfsr_step(lfsr);
    if (lfsr == WRAP_CODE) lfsr_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset || rsync) begin
      ph     <= '0;
      lfsr   <= '0;
      shs    <= 1'b0;
      rhs    <= 1'b0;
      rcb    <= 1'b0;
      rhb    <= 1'b0;
      lrhb   <= 1'b0;
      shb    <= 1'b0;
      hsync  <= 1'b0;
      hblank <= 1'b1;
    end else begin
      ph <= ph + PH_W'(1);
      if (ph == PH_W'(3)) lfsr <= lfsr_next;

      shb  <= decode_now && (lfsr == SHB_CODE);
      shs  <= decode_now && (lfsr == SHS_CODE);
      rhs  <= decode_now && (lfsr == RHS_CODE);
      rcb  <= decode_now && (lfsr == RCB_CODE);
      rhb  <= decode_now && (lfsr == RHB_CODE);
      lrhb <= decode_now && (lfsr == LRHB_CODE);

      if (shs)      hsync <= 1'b1;
      else if (rhs) hsync <= 1'b0;

      // hmove_late picks which reset-HBLANK pulse ends blanking this line.
      if (shb)                           hblank <= 1'b1;
      else if (rhb && !hmove_late)       hblank <= 1'b0;
      else if (lrhb && hmove_late)       hblank <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tia_hcounter.sv
// Bench for tia_hcounter: directed line scenarios plus randomized rsync/reset/
// hmove_late traffic against a cycle-position reference model.
module tb_tia_hcounter;

  logic       clk = 1'b0;
  logic       reset, rsync, hmove_late;
  logic       hphi1, hphi2;
  logic [5:0] lfsr;
  logic       shs, rhs, rcb, rhb, lrhb, shb, hsync, hblank;

  tia_hcounter dut (
    .clk(clk), .reset(reset), .rsync(rsync), .hmove_late(hmove_late),
    .hphi1(hphi1), .hphi2(hphi2), .lfsr(lfsr),
    .shs(shs), .rhs(rhs), .rcb(rcb), .rhb(rhb), .lrhb(lrhb), .shb(shb),
    .hsync(hsync), .hblank(hblank)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned t = 0;
  bit          hb_m = 1'b1;
  int          cyc = 0;
  int          last_shb = -1;
  logic [5:0]  code [57];
  bit          seen [64];
  int          distinct = 0;
  bit          collect = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0d)", tag, got, exp, cyc, t);
    end
  endtask

  // Compare the current cycle to the model, then apply inputs for this cycle.
  task automatic step(input bit r, input bit rs, input bit hl);
    int unsigned ph_m, k, p;
    @(negedge clk);
    ph_m = t % 4;
    k    = (t / 4) % 57;
    p    = t % 228;
    check("hphi1",  32'(hphi1),  32'(ph_m == 0));
    check("hphi2",  32'(hphi2),  32'(ph_m == 2));
    check("lfsr",   32'(lfsr),   32'(code[k]));
    check("shb",    32'(shb),    32'(ph_m == 3 && k == 0));
    check("shs",    32'(shs),    32'(ph_m == 3 && k == 4));
    check("rhs",    32'(rhs),    32'(ph_m == 3 && k == 8));
    check("rcb",    32'(rcb),    32'(ph_m == 3 && k == 12));
    check("rhb",    32'(rhb),    32'(ph_m == 3 && k == 16));
    check("lrhb",   32'(lrhb),   32'(ph_m == 3 && k == 18));
    check("hsync",  32'(hsync),  32'(p >= 20 && p < 36));
    check("hblank", 32'(hblank), 32'(hb_m));
    if (collect && ph_m == 0 && !seen[lfsr]) begin
      seen[lfsr] = 1'b1;
      distinct++;
    end
    if (shb === 1'b1) begin
      if (last_shb >= 0) check("line_period", 32'(cyc - last_shb), 32'd228);
      last_shb = cyc;
    end
    reset      = r;
    rsync      = rs;
    hmove_late = hl;
    @(posedge clk);
    cyc++;
    if (r || rs) begin
      t        = 0;
      hb_m     = 1'b1;
      last_shb = -1;
    end else begin
      if (ph_m == 3 && k == 0)                                 hb_m = 1'b1;
      else if (ph_m == 3 && ((k == 16 && !hl) || (k == 18 && hl))) hb_m = 1'b0;
      t++;
    end
  endtask

  initial begin
    code[0] = 6'b000000;
    for (int i = 1; i < 57; i++) code[i] = {code[i-1][4:0], ~(code[i-1][5] ^ code[i-1][4])};
    reset = 1'b1; rsync = 1'b0; hmove_late = 1'b0;
    repeat (2) @(posedge clk);

    // Two clean lines with early HBLANK end; gather one line of LFSR codes.
    collect = 1'b1;
    for (int i = 0; i < 228; i++) step(1'b0, 1'b0, 1'b0);
    collect = 1'b0;
    check("lfsr_distinct", 32'(distinct), 32'd57);
    for (int i = 0; i < 240; i++) step(1'b0, 1'b0, 1'b0);

    // Late HBLANK end for a line and a half.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 340; i++) step(1'b0, 1'b0, 1'b1);

    // rsync at cycle 25 while hsync is high.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 80; i++) step(1'b0, 1'b0, 1'b0);

    // rsync held high stays parked at count 0.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

    // Reset and rsync together at cycle 100, reset held three more clocks.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tia_hcounter.md
Name: tia_hcounter

Overview:
- Single-clock horizontal timing stage for the TIA model; sits directly downstream of the D2 shift-stage primitives and replaces their two-phase s1/s2 chain with one color clock.
- Divides the color clock by 4 into one-cycle phase strobes, hphi1 and hphi2.
- Advances a 6-bit polynomial counter (LFSR) once per 4 clocks, wrapping every 57 counts, i.e. 228 clocks per line.
- Decodes the LFSR into HSYNC/HBLANK control pulses and levels consumed by the sync/blank and object stages.

Parameters:
WRAP_COUNT, 56, count index at which the LFSR reloads 000000; line length = (WRAP_COUNT+1)*4 clocks.

Ports:
clk  input  1  color clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
rsync  input  1  synchronous strobe (RSYNC register write); restarts the line.
hmove_late  input  1  level; selects the late HBLANK end.
hphi1  output  1  one-cycle strobe, phase 0.
hphi2  output  1  one-cycle strobe, phase 2.
lfsr  output  6  polynomial counter state.
shs  output  1  set-HSYNC decode pulse.
rhs  output  1  reset-HSYNC decode pulse.
rcb  output  1  reset-color-burst decode pulse.
rhb  output  1  reset-HBLANK decode pulse.
lrhb  output  1  late reset-HBLANK decode pulse.
shb  output  1  set-HBLANK pulse (line start).
hsync  output  1  HSYNC level.
hblank  output  1  HBLANK level.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high.
  - reset has priority over rsync, and rsync over normal counting.
  - Reset values: ph=0, lfsr=000000, hsync=0, hblank=1, all decode pulses 0.
- Phase counter ph (2 bits):
  - Increments every clk, 3 wraps to 0.
  - hphi1 = (ph==0); hphi2 = (ph==2). Combinational from ph, so low for no extra cycle.
- LFSR:
  - Advances only on a clk edge where ph==3.
  - Next state = {lfsr[4:0], ~(lfsr[5]^lfsr[4])}.
  - Sequence from 000000: 000001, 000011, 000111, 001111, 011111, 111110, 111101, 111011, ...
  - Count index k = number of advances since the last 000000.
  - When lfsr equals the code for index WRAP_COUNT and ph==3, the next state is 000000, not the shift result.
  - The wrap code is a constant derived from the sequence at elaboration.
  - All-ones (lockup) is unreachable from reset; if forced, the LFSR stays there until reset/rsync. Not recovered.
- Decodes:
  - One-clk pulses, registered, asserted in the cycle after ph==2 of the stated count index.
  - Equivalently, the pulse is high during the ph==3 cycle of that count.
  - Indices: shb 0, shs 4, rhs 8, rcb 12, rhb 16, lrhb 18.
  - Every decode pulses every line regardless of hmove_late.
- Levels (registered, updated on the clk after the pulse):
  - hsync: set by shs, cleared by rhs.
  - hblank: set by shb.
  - hblank clear: by rhb when hmove_late=0, by lrhb when hmove_late=1; hmove_late is sampled in the pulse cycle.
  - Set and clear never coincide.
- rsync:
  - On the clk edge with rsync=1: ph<=0, lfsr<=000000, hsync<=0, hblank<=1, pending pulses cleared.
  - The next cycle is count 0, ph 0, identical to post-reset.
  - rsync held high keeps the block parked at count 0, ph 0.
- Reset or rsync mid-line truncates the line with no partial pulses.
- Timing reference: after reset deasserts, first cycle = cycle 0.
  - Count k occupies cycles 4k..4k+3.
  - Decode for index k pulses at cycle 4k+3.
  - The level changes at cycle 4k+4.

Test Plan:
- Reset, run 8 clks -> hphi1 at cycles 0,4; hphi2 at 2,6; lfsr 000000 cycles 0-3, 000001 cycles 4-7; hblank=1, hsync=0.
- Free-run 228 clks -> shs at 19, hsync=1 from 20; rhs at 35, hsync=0 from 36 (width 16); rcb at 51; lfsr back to 000000 at cycle 228.
- hmove_late=0 -> rhb at 67, hblank=0 from 68. hmove_late=1 -> rhb still pulses at 67, hblank stays 1; lrhb at 75, hblank=0 from 76.
- Run two lines -> shb at 231, hblank=1 from 232 until 296 (rhb at 295); period exactly 228 clocks; all 57 LFSR codes distinct.
- rsync pulse at cycle 25 (hsync=1) -> cycle 26: ph=0, lfsr=000000, hsync=0, hblank=1; shs at 26+19=45.
- reset and rsync asserted together at cycle 100, then reset held 3 clks -> state held at reset values; sequence restarts cleanly after deassert.
